// File: rtl/one_hot_serializer.sv
// MSB-first parallel-to-serial converter for the encoder's one-hot words.
// Sends 1..WIDTH bits per request. Requests that arrive while it is busy are dropped.
module one_hot_serializer #(
  parameter int WIDTH = 5,
  parameter int MOD_W = $clog2(WIDTH+1)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [MOD_W-1:0] data_mod_i,
  input  logic             data_val_i,
  output logic             ser_data_o,
  output logic             ser_data_val_o,
  output logic             busy_o
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [MOD_W-1:0] LP_WIDTH = MOD_W'(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [MOD_W-1:0] r_cnt;
  logic             r_ser;
  logic             r_val;
  logic             r_busy;

  logic             w_legal;
  logic [MOD_W-1:0] w_cnt;

  assign w_legal = (data_mod_i <= LP_WIDTH);
  assign w_cnt   = (data_mod_i == '0) ? LP_WIDTH : data_mod_i;

  // The first bit is registered at the accepting edge. r_cnt then counts the bits still to emit after the current one.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_ser   <= 1'b0;
      r_val   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (data_val_i && w_legal) begin
            r_ser   <= data_i[WIDTH-1];
            r_val   <= 1'b1;
            r_busy  <= 1'b1;
            r_shift <= data_i << 1;
            r_cnt   <= w_cnt - MOD_W'(1);
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (r_cnt == '0) begin
            r_ser   <= 1'b0;
            r_val   <= 1'b0;
            r_busy  <= 1'b0;
            r_shift <= '0;
            r_state <= IDLE;
          end else begin
            r_ser   <= r_shift[WIDTH-1];
            r_shift <= r_shift << 1;
            r_cnt   <= r_cnt - MOD_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ser_data_o     = r_ser;
  assign ser_data_val_o = r_val;
  assign busy_o         = r_busy;

endmodule

// File: tb/tb_one_hot_serializer.sv
// Directed bench for one_hot_serializer. A queue model of the pending bits is checked on every cycle.
// Hand-written literal sequences pin both the model and the DUT.
module tb_one_hot_serializer;

  logic       clk = 1'b0;
  logic       srst;
  logic [4:0] data;
  logic [2:0] mod;
  logic       val;
  logic       ser, ser_val, busy;

  int checks   = 0;
  int failures = 0;

  one_hot_serializer #(.WIDTH(5)) dut (
    .clk_i(clk), .srst_i(srst), .data_i(data), .data_mod_i(mod),
    .data_val_i(val), .ser_data_o(ser), .ser_data_val_o(ser_val), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // The model queue holds the bits still due, starting with the bit shown this cycle.
  bit q[$];
  bit m_was_busy;
  int m_n;

  always @(posedge clk) begin
    m_was_busy = (q.size() != 0);
    if (srst) q.delete();
    else begin
      if (q.size() != 0) void'(q.pop_front());
      if (!m_was_busy && val && mod <= 3'd5) begin
        m_n = (mod == 3'd0) ? 5 : int'(mod);
        for (int k = 0; k < m_n; k++) q.push_back(data[4-k]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic ev, eb;
    ev = (q.size() != 0);
    eb = ev ? q[0] : 1'b0;
    chk("model_val",  {31'd0, ser_val}, {31'd0, ev});
    chk("model_busy", {31'd0, busy},    {31'd0, ev});
    chk("model_data", {31'd0, ser},     {31'd0, eb});
  end

  // Issue a request with a one-cycle valid. The task returns at the negedge right after the accepting edge.
  task automatic req(input logic [4:0] d, input logic [2:0] m);
    data = d; mod = m; val = 1'b1;
    @(negedge clk);
    val = 1'b0;
  endtask

  // Expect n bits (MSB of the n-bit field first), then one idle cycle.
  task automatic expect_bits(input string name, input logic [4:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      chk({name, "_val"},  {31'd0, ser_val}, 32'd1);
      chk({name, "_busy"}, {31'd0, busy},    32'd1);
      chk({name, "_bit"},  {31'd0, ser},     {31'd0, bits[n-1-i]});
      @(negedge clk);
    end
    chk({name, "_endval"},  {31'd0, ser_val}, 32'd0);
    chk({name, "_endbusy"}, {31'd0, busy},    32'd0);
    chk({name, "_endbit"},  {31'd0, ser},     32'd0);
  endtask

  task automatic expect_idle(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      chk({name, "_val"},  {31'd0, ser_val}, 32'd0);
      chk({name, "_busy"}, {31'd0, busy},    32'd0);
      chk({name, "_bit"},  {31'd0, ser},     32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset held for two cycles while a request is presented.
    srst = 1'b1; val = 1'b1; data = 5'b11111; mod = 3'd0;
    @(negedge clk);
    @(negedge clk);
    expect_idle("rst_hold", 1);
    srst = 1'b0; val = 1'b0;
    @(negedge clk);
    expect_idle("rst_after", 3);

    // Full word, mod 0 -> 5 bits.
    req(5'b10000, 3'd0);
    expect_bits("full", 5'b10000, 5);
    @(negedge clk);

    // Partial word: only the top 3 bits are sent.
    req(5'b01100, 3'd3);
    expect_bits("part", 5'b00011, 3);
    expect_idle("part_idle", 2);

    // A request held valid while busy is dropped, then taken on the first idle cycle.
    data = 5'b00001; mod = 3'd5; val = 1'b1;
    @(negedge clk);
    data = 5'b11111;
    for (int i = 0; i < 5; i++) begin
      chk("b2b_first_val", {31'd0, ser_val}, 32'd1);
      chk("b2b_first_bit", {31'd0, ser}, {31'd0, (i == 4) ? 1'b1 : 1'b0});
      @(negedge clk);
    end
    chk("b2b_gap_val",  {31'd0, ser_val}, 32'd0);
    chk("b2b_gap_busy", {31'd0, busy},    32'd0);
    @(negedge clk);
    val = 1'b0;
    expect_bits("b2b_second", 5'b11111, 5);
    @(negedge clk);

    // Illegal counts are dropped silently.
    req(5'b11111, 3'd6);
    expect_idle("ill6", 2);
    req(5'b11111, 3'd7);
    expect_idle("ill7", 1);
    req(5'b00100, 3'd5);
    expect_bits("after_ill", 5'b00100, 5);

    // Reset after two bits aborts the transfer.
    req(5'b11111, 3'd5);
    chk("mid_bit1", {31'd0, ser}, 32'd1);
    @(negedge clk);
    chk("mid_bit2", {31'd0, ser}, 32'd1);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    expect_idle("mid_abort", 5);
    req(5'b01010, 3'd0);
    expect_bits("mid_next", 5'b01010, 5);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
